// File: rtl/spi_pkg.sv
// Shared constants for the 64-bit SPI master: frame width, SPI mode and FSM encodings.
package spi_pkg;

    localparam int DATA_LENGTH = 32;
    localparam int WORD_LENGTH = 2 * DATA_LENGTH;

    // Only mode 0 is implemented: SCLK idles low, data sampled on the leading edge.
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    // Per-frame phases, owned by the frame engine.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_TRAIL
    } state_t;

    // Word-level sequencing, owned by the top level.
    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_FRAME,
        SEQ_GAP,
        SEQ_DONE
    } seq_t;

    // Width of a counter that runs 0..n-1 (never narrower than one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/m_spi_control.sv
// Single-frame SPI mode-0 engine: SETUP, DATA_LEN SCLK periods, TRAIL; 66*CLK_DIV cycles per frame.
// load_i is only honoured while idle; busy_o drops in the final TRAIL cycle so the sequencer can act on the next edge.
module m_spi_control
    import spi_pkg::*;
#(
    parameter int DATA_LEN = DATA_LENGTH,
    parameter int CLK_DIV  = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic [DATA_LEN-1:0] data_i,
    output logic [DATA_LEN-1:0] data_o,
    output logic                busy_o,
    output logic                sclk_o,
    output logic                mosi_o,
    output logic                ss_o,
    input  logic                miso_i
);

    localparam int DW = cnt_width(CLK_DIV);
    localparam int BW = cnt_width(DATA_LEN);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_LEN - 1);

    state_t              phase_q;
    logic [DW-1:0]       div_q;
    logic [BW-1:0]       bit_q;
    logic [DATA_LEN-1:0] tx_q;
    logic [DATA_LEN-1:0] rx_q;
    logic                sclk_q;
    logic                ss_q;
    logic                div_end;

    assign div_end = (div_q == DIV_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            sclk_q  <= CPOL;
            ss_q    <= 1'b1;
        end else begin
            case (phase_q)
                ST_IDLE: begin
                    if (load_i) begin
                        phase_q <= ST_SETUP;
                        div_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= data_i;
                        sclk_q  <= CPOL;
                        ss_q    <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (div_end) begin
                        phase_q <= ST_SHIFT;
                        div_q   <= '0;
                        sclk_q  <= ~CPOL;
                        rx_q    <= {rx_q[DATA_LEN-2:0], miso_i};
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (div_end) begin
                        div_q <= '0;
                        if (sclk_q != CPOL) begin
                            // Falling edge: present the next bit, but leave the last one in place.
                            sclk_q <= CPOL;
                            if (bit_q != BIT_LAST) begin
                                tx_q <= {tx_q[DATA_LEN-2:0], 1'b0};
                            end
                        end else if (bit_q == BIT_LAST) begin
                            phase_q <= ST_TRAIL;
                        end else begin
                            bit_q  <= bit_q + 1'b1;
                            sclk_q <= ~CPOL;
                            rx_q   <= {rx_q[DATA_LEN-2:0], miso_i};
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                ST_TRAIL: begin
                    if (div_end) begin
                        phase_q <= ST_IDLE;
                        div_q   <= '0;
                        tx_q    <= '0;
                        ss_q    <= 1'b1;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                default: phase_q <= ST_IDLE;
            endcase
        end
    end

    assign data_o = rx_q;
    assign busy_o = (phase_q != ST_IDLE) && !((phase_q == ST_TRAIL) && div_end);
    assign sclk_o = sclk_q;
    assign mosi_o = tx_q[DATA_LEN-1];
    assign ss_o   = ss_q;

endmodule

// File: rtl/m_64spi.sv
// 64-bit SPI master: two 32-bit frames (low half first) separated by an SS-high gap; done 1+132*CLK_DIV+SS_GAP cycles after start.
// start is ignored while status_o is high (never queued); out_i is captured once per accepted start.
module m_64spi
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int SS_GAP  = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   start_i,
    input  logic [WORD_LENGTH-1:0] out_i,
    output logic [WORD_LENGTH-1:0] in_o,
    output logic                   status_o,
    output logic                   done_o,
    output logic                   sclk_o,
    output logic                   mosi_o,
    input  logic                   miso_i,
    output logic                   ss_o
);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("CLK_DIV must be at least 2");
    end
    if (SS_GAP < 4) begin : g_bad_gap
        $error("SS_GAP must be at least 4");
    end
    if (CPOL != 1'b0 || CPHA != 1'b0) begin : g_bad_mode
        $error("only SPI mode 0 is implemented");
    end

    localparam int GW = cnt_width(SS_GAP);
    // The load is registered, so it is issued one cycle before the gap ends.
    localparam logic [GW-1:0] GAP_LOAD = GW'(SS_GAP - 2);
    localparam logic [GW-1:0] GAP_LAST = GW'(SS_GAP - 1);

    seq_t                   seq_q;
    logic [WORD_LENGTH-1:0] tx_q;
    logic [WORD_LENGTH-1:0] in_q;
    logic [DATA_LENGTH-1:0] rx_lo_q;
    logic [GW-1:0]          gap_q;
    logic                   idx_q;
    logic                   load_q;
    logic                   status_q;
    logic                   done_q;

    logic [DATA_LENGTH-1:0] frame_tx;
    logic [DATA_LENGTH-1:0] frame_rx;
    logic                   frame_busy;

    assign frame_tx = idx_q ? tx_q[WORD_LENGTH-1:DATA_LENGTH] : tx_q[DATA_LENGTH-1:0];

    m_spi_control #(
        .DATA_LEN (DATA_LENGTH),
        .CLK_DIV  (CLK_DIV)
    ) u_ctrl (
        .clk_i  (clk_i),
        .rst_ni (reset_ni),
        .load_i (load_q),
        .data_i (frame_tx),
        .data_o (frame_rx),
        .busy_o (frame_busy),
        .sclk_o (sclk_o),
        .mosi_o (mosi_o),
        .ss_o   (ss_o),
        .miso_i (miso_i)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            seq_q    <= SEQ_IDLE;
            tx_q     <= '0;
            in_q     <= '0;
            rx_lo_q  <= '0;
            gap_q    <= '0;
            idx_q    <= 1'b0;
            load_q   <= 1'b0;
            status_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            load_q <= 1'b0;
            done_q <= 1'b0;
            case (seq_q)
                // The done cycle accepts a new start exactly like idle.
                SEQ_IDLE, SEQ_DONE: begin
                    if (start_i) begin
                        seq_q    <= SEQ_FRAME;
                        tx_q     <= out_i;
                        idx_q    <= 1'b0;
                        load_q   <= 1'b1;
                        status_q <= 1'b1;
                    end else begin
                        seq_q <= SEQ_IDLE;
                    end
                end
                SEQ_FRAME: begin
                    if (!load_q && !frame_busy) begin
                        if (!idx_q) begin
                            seq_q   <= SEQ_GAP;
                            gap_q   <= '0;
                            rx_lo_q <= frame_rx;
                        end else begin
                            seq_q    <= SEQ_DONE;
                            in_q     <= {frame_rx, rx_lo_q};
                            done_q   <= 1'b1;
                            status_q <= 1'b0;
                        end
                    end
                end
                SEQ_GAP: begin
                    gap_q <= gap_q + 1'b1;
                    if (gap_q == GAP_LOAD) begin
                        idx_q  <= 1'b1;
                        load_q <= 1'b1;
                    end
                    if (gap_q == GAP_LAST) begin
                        seq_q <= SEQ_FRAME;
                    end
                end
                default: seq_q <= SEQ_IDLE;
            endcase
        end
    end

    assign in_o     = in_q;
    assign status_o = status_q;
    assign done_o   = done_q;

    a_ss_sclk: assert property (@(posedge clk_i) disable iff (!reset_ni) ss_o |-> !sclk_o);
    a_done_idle: assert property (@(posedge clk_i) disable iff (!reset_ni) done_o |-> !status_o);

endmodule

// File: tb/tb_m_64spi.sv
// Bench for m_64spi looped to a behavioural 64-bit SPI slave; vector table plus scoreboarded corner sequences.
module tb_m_64spi;

    localparam int CLK_DIV = 4;
    localparam int SS_GAP  = 8;
    localparam int LAT     = 1 + 2 * (66 * CLK_DIV) + SS_GAP;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] out_w;
    logic [63:0] in_w;
    logic        status, done, sclk, mosi, miso, ss;

    m_64spi #(
        .CLK_DIV (CLK_DIV),
        .SS_GAP  (SS_GAP)
    ) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .start_i  (start),
        .out_i    (out_w),
        .in_o     (in_w),
        .status_o (status),
        .done_o   (done),
        .sclk_o   (sclk),
        .mosi_o   (mosi),
        .miso_i   (miso),
        .ss_o     (ss)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 64-bit mode-0 slave: frame 0 carries the low half.
    logic [63:0] s_tx = '0;
    logic [63:0] s_rx = '0;
    logic [31:0] s_sh_tx = '0;
    logic [31:0] s_sh_rx = '0;
    logic        s_miso = 1'b0;
    logic        s_ss_p = 1'b1, s_sclk_p = 1'b0, s_st_p = 1'b0;
    int          s_frame = 0;
    bit          force_en = 1'b0;
    bit          force_val = 1'b0;

    assign miso = force_en ? force_val : s_miso;

    always @(ss or sclk or status) begin
        if (status === 1'b1 && s_st_p !== 1'b1) s_frame = 0;
        if (ss !== s_ss_p) begin
            if (ss === 1'b0) begin
                s_sh_tx = (s_frame == 0) ? s_tx[31:0] : s_tx[63:32];
                s_miso  = s_sh_tx[31];
            end else if (ss === 1'b1 && s_ss_p === 1'b0) begin
                if (s_frame == 0) s_rx[31:0] = s_sh_rx;
                else if (s_frame == 1) s_rx[63:32] = s_sh_rx;
                s_frame++;
            end
        end else if (sclk !== s_sclk_p && ss === 1'b0) begin
            if (sclk === 1'b1) begin
                s_sh_rx = {s_sh_rx[30:0], mosi};
            end else begin
                s_sh_tx = {s_sh_tx[30:0], 1'b0};
                s_miso  = s_sh_tx[31];
            end
        end
        s_ss_p   = ss;
        s_sclk_p = sclk;
        s_st_p   = status;
    end

    // Pin monitor: per-window first MOSI bit, SCLK rising edges, preceding SS-high run.
    int   rises_q[$];
    int   gaps_q[$];
    logic fm_q[$];
    int   gap_run = 0, rise_run = 0, bad_n = 0;
    logic m_ss_p = 1'b1, m_sclk_p = 1'b0;

    always @(negedge clk) begin
        if (ss === 1'b0 && m_ss_p === 1'b1) begin
            gaps_q.push_back(gap_run);
            fm_q.push_back(mosi);
            rise_run = 0;
        end
        if (ss === 1'b1 && m_ss_p === 1'b0) rises_q.push_back(rise_run);
        if (ss === 1'b0 && sclk === 1'b1 && m_sclk_p !== 1'b1) rise_run++;
        if (ss === 1'b1) gap_run++;
        else gap_run = 0;
        if (ss === 1'b1 && sclk === 1'b1) bad_n++;
        m_ss_p   = ss;
        m_sclk_p = sclk;
    end

    typedef struct {
        logic [63:0] m_out;
        logic [63:0] s_out;
        bit          f_en;
        bit          f_val;
        logic [63:0] exp_in;
        logic [63:0] exp_sin;
    } vec_t;

    typedef struct {
        logic [63:0] exp_in;
        logic [63:0] exp_sin;
        int unsigned acc;
    } sb_t;

    sb_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic launch(input logic [63:0] w, input logic [63:0] e_in, input logic [63:0] e_sin);
        @(negedge clk);
        out_w = w;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sb_q.push_back('{exp_in: e_in, exp_sin: e_sin, acc: cyc});
        chk("status after start", {63'd0, status}, 64'd1);
    endtask

    task automatic collect(input string nm);
        sb_t e;
        bit  seen = 1'b0;
        for (int i = 0; i < LAT + 50; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!seen || sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s done: seen=%0d pending=%0d, expected a done pulse for a pending transfer", nm, seen, sb_q.size());
            if (sb_q.size() != 0) void'(sb_q.pop_front());
        end else begin
            e = sb_q.pop_front();
            chk({nm, " in"}, in_w, e.exp_in);
            chk({nm, " latency"}, 64'(cyc - e.acc), 64'(LAT));
            chk({nm, " status at done"}, {63'd0, status}, 64'd0);
            chk({nm, " slave in"}, s_rx, e.exp_sin);
        end
    endtask

    vec_t        vt[5];
    logic [63:0] prev;
    int          n0, r0, b0, extra;
    bit          hit;

    initial begin
        vt[0] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
        vt[1] = '{64'hA5A5_5A5A_F00F_0FF0, 64'h3C3C_C3C3_1234_8765, 1'b0, 1'b0, 64'h3C3C_C3C3_1234_8765, 64'hA5A5_5A5A_F00F_0FF0};
        vt[2] = '{64'hDEAD_BEEF_CAFE_F00D, 64'h0000_0000_0000_0000, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hDEAD_BEEF_CAFE_F00D};
        vt[3] = '{64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'h0000_0000_0000_0000, 64'h0000_0001_8000_0000};
        vt[4] = '{64'h8000_0000_0000_0001, 64'h0000_0001_8000_0000, 1'b0, 1'b0, 64'h0000_0001_8000_0000, 64'h8000_0000_0000_0001};

        rst_n = 1'b0;
        start = 1'b0;
        out_w = '0;
        repeat (3) @(negedge clk);
        chk("reset ss", {63'd0, ss}, 64'd1);
        chk("reset sclk", {63'd0, sclk}, 64'd0);
        chk("reset mosi", {63'd0, mosi}, 64'd0);
        chk("reset status", {63'd0, status}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset in", in_w, 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Vector table: data path, latency and framing on the pins.
        foreach (vt[k]) begin
            s_tx      = vt[k].s_out;
            force_en  = vt[k].f_en;
            force_val = vt[k].f_val;
            n0 = fm_q.size();
            r0 = rises_q.size();
            b0 = bad_n;
            launch(vt[k].m_out, vt[k].exp_in, vt[k].exp_sin);
            collect($sformatf("vec%0d", k));
            @(negedge clk);
            chk($sformatf("vec%0d windows", k), 64'(fm_q.size() - n0), 64'd2);
            if (fm_q.size() >= n0 + 2 && rises_q.size() >= r0 + 2) begin
                chk($sformatf("vec%0d f0 first mosi", k), {63'd0, fm_q[n0]}, {63'd0, vt[k].m_out[31]});
                chk($sformatf("vec%0d f1 first mosi", k), {63'd0, fm_q[n0+1]}, {63'd0, vt[k].m_out[63]});
                chk($sformatf("vec%0d f0 rises", k), 64'(rises_q[r0]), 64'd32);
                chk($sformatf("vec%0d f1 rises", k), 64'(rises_q[r0+1]), 64'd32);
                chk($sformatf("vec%0d ss gap", k), 64'(gaps_q[n0+1]), 64'(SS_GAP));
            end
            chk($sformatf("vec%0d sclk idle", k), 64'(bad_n - b0), 64'd0);
        end
        force_en = 1'b0;

        // Start and out changes while busy are ignored.
        s_tx = 64'h1111_2222_3333_4444;
        prev = in_w;
        launch(64'h5555_6666_7777_8888, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
        repeat (100) @(negedge clk);
        out_w = '1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("in held while busy", in_w, prev);
        collect("busy start");
        extra = 0;
        repeat (600) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        chk("no queued transfer", 64'(extra), 64'd0);
        chk("idle after ignore", {63'd0, status}, 64'd0);

        // Asynchronous reset in frame 1 with SCLK high.
        s_tx = 64'hAAAA_BBBB_CCCC_DDDD;
        n0 = fm_q.size();
        launch(64'h1357_9BDF_2468_ACE0, 64'd0, 64'd0);
        hit = 1'b0;
        for (int i = 0; i < 2 * LAT; i++) begin
            @(negedge clk);
            if (fm_q.size() >= n0 + 2 && sclk === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reached frame1 sclk high", {63'd0, hit}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort ss", {63'd0, ss}, 64'd1);
        chk("abort sclk", {63'd0, sclk}, 64'd0);
        chk("abort mosi", {63'd0, mosi}, 64'd0);
        chk("abort in", in_w, 64'd0);
        chk("abort status", {63'd0, status}, 64'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        s_tx = 64'h0F1E_2D3C_4B5A_6978;
        launch(64'hC001_D00D_BAAD_F00D, 64'h0F1E_2D3C_4B5A_6978, 64'hC001_D00D_BAAD_F00D);
        collect("after reset");

        // Start held high: back-to-back transfers accepted in each done cycle.
        s_tx  = 64'h7E57_0000_FFFF_1234;
        @(negedge clk);
        out_w = 64'h0BAD_CAFE_1357_2468;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            sb_q.push_back('{exp_in: 64'h7E57_0000_FFFF_1234, exp_sin: 64'h0BAD_CAFE_1357_2468, acc: cyc});
            chk($sformatf("b2b%0d status rise", k), {63'd0, status}, 64'd1);
            collect($sformatf("b2b%0d", k));
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle after b2b", {63'd0, status}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
